// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-PC sequencer: next-PC source select,
// alignment mask and the RAS occupancy-counter width helper.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_HOLD  = 3'd1,
        SEL_RAS   = 3'd2,
        SEL_REDIR = 3'd3,
        SEL_TRAP  = 3'd4
    } next_sel_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Counter must represent 0..depth inclusive, hence one bit above the index width.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the hazard/branch logic and the fetch-PC sequencer.
// Slave is the sequencer side; master drives the control inputs.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int XLEN = 32'sd32,
    parameter int CW   = cnt_w(32'sd4)
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_inc;
    logic            pc_valid;
    logic            misalign_trap;
    logic            ras_underflow;
    logic [CW-1:0]   ras_count;

    modport master (
        output stall, redirect_valid, redirect_target, trap, ras_push, ras_pop,
        input  pc, pc_plus_inc, pc_valid, misalign_trap, ras_underflow, ras_count
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap, ras_push, ras_pop,
        output pc, pc_plus_inc, pc_valid, misalign_trap, ras_underflow, ras_count
    );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// occupancy saturates at RAS_DEPTH, flush empties it in one cycle.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int XLEN      = 32'sd32,
    parameter int RAS_DEPTH = 32'sd4,
    parameter int CW        = cnt_w(RAS_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic [CW-1:0]   count
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem_r [RAS_DEPTH];
    logic [PW-1:0]   ptr_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   top_idx_s;
    logic            full_s;

    assign top_idx_s = ptr_r - PW'(1);
    assign full_s    = (count_r == CW'(RAS_DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign top       = mem_r[top_idx_s];
    assign count     = count_r;

    // Stack storage, write pointer and occupancy; ptr points at the next free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
            ptr_r   <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            ptr_r   <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (push && pop && !empty) begin
            // Pop consumes the old top; the push takes over that same slot.
            mem_r[top_idx_s] <= push_data;
        end else if (push) begin
            mem_r[ptr_r] <= push_data;
            ptr_r        <= ptr_r + PW'(1);
            count_r      <= full_s ? count_r : count_r + CW'(1);
        end else if (pop && !empty) begin
            ptr_r   <= top_idx_s;
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC generator: prioritised next-PC mux (trap, misaligned redirect, redirect,
// stall, RAS return, sequential), PC register, RAS and single-cycle status pulses.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN      = 32'sd32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              INC       = 32'sd4,
    parameter int              RAS_DEPTH = 32'sd4
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int              CW    = cnt_w(RAS_DEPTH);
    localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

    next_sel_e       sel_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_inc_s;
    logic [XLEN-1:0] pc_nxt_s;
    logic            pc_valid_r;
    logic            misalign_s;
    logic            misalign_r;
    logic            underflow_s;
    logic            underflow_r;
    logic            push_s;
    logic            pop_s;
    logic            flush_s;
    logic [XLEN-1:0] ras_top_s;
    logic            ras_empty_s;
    logic [CW-1:0]   ras_cnt_s;

    assign pc_inc_s = pc_r + INC_V;

    // Next-PC source priority; the first post-reset cycle holds like a stall.
    always_comb begin
        sel_s      = SEL_SEQ;
        misalign_s = 1'b0;
        if (bus.trap) begin
            sel_s = SEL_TRAP;
        end else if (bus.redirect_valid && ((bus.redirect_target[1:0] & ALIGN_MASK) != 2'b00)) begin
            sel_s      = SEL_TRAP;
            misalign_s = 1'b1;
        end else if (bus.redirect_valid) begin
            sel_s = SEL_REDIR;
        end else if (bus.stall || !pc_valid_r) begin
            sel_s = SEL_HOLD;
        end else if (bus.ras_pop && !ras_empty_s) begin
            sel_s = SEL_RAS;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Next-PC mux.
    always_comb begin
        pc_nxt_s = pc_inc_s;
        unique case (sel_s)
            SEL_TRAP:  pc_nxt_s = TRAP_VEC;
            SEL_REDIR: pc_nxt_s = bus.redirect_target;
            SEL_HOLD:  pc_nxt_s = pc_r;
            SEL_RAS:   pc_nxt_s = ras_top_s;
            SEL_SEQ:   pc_nxt_s = pc_inc_s;
            default:   pc_nxt_s = pc_inc_s;
        endcase
    end

    // RAS operations only take effect while the PC advances; traps flush it.
    always_comb begin
        push_s  = 1'b0;
        pop_s   = 1'b0;
        flush_s = 1'b0;
        if (sel_s == SEL_TRAP) begin
            flush_s = 1'b1;
        end else if (sel_s == SEL_REDIR || sel_s == SEL_RAS || sel_s == SEL_SEQ) begin
            push_s = bus.ras_push;
            pop_s  = bus.ras_pop;
        end else begin
            flush_s = 1'b0;
        end
    end

    assign underflow_s = pop_s & ras_empty_s;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH),
        .CW        (CW)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .push_data (pc_inc_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s),
        .count     (ras_cnt_s)
    );

    // PC register, valid flag and status pulse flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r        <= RESET_VEC;
            pc_valid_r  <= 1'b0;
            misalign_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            pc_r        <= pc_nxt_s;
            pc_valid_r  <= 1'b1;
            misalign_r  <= misalign_s;
            underflow_r <= underflow_s;
        end
    end

    assign bus.pc            = pc_r;
    assign bus.pc_plus_inc   = pc_inc_s;
    assign bus.pc_valid      = pc_valid_r;
    assign bus.misalign_trap = misalign_r;
    assign bus.ras_underflow = underflow_r;
    assign bus.ras_count     = ras_cnt_s;

endmodule
